// File: rtl/lsu_sram.sv
// Single-outstanding AXI4 slave SRAM for the LSU data port (32-bit, single beat, word aligned).
// Define LSU_SRAM_RAND_DELAY_EN to add a 0..3 cycle LFSR jitter on top of DELAY.
module lsu_sram #(
    parameter logic [31:0] BASE   = 32'h8000_0000,
    parameter int unsigned AW_IDX = 10,
    parameter int unsigned DELAY  = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic [3:0]  rid
);
    localparam int unsigned WORDS  = 1 << AW_IDX;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic [2:0] {
        StIdle, StRdWait, StRdResp, StWrCollect, StWrWait, StWrResp
    } state_e;

    state_e        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d, load;
    logic          aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [31:0]   awaddr_q, wdata_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d, bresp_q, bresp_d;
    logic [31:0]   mem [WORDS];

    logic          ar_hs, aw_hs, w_hs, aw_have, w_have, commit;
    logic [31:0]   wr_addr, wr_data;
    logic [3:0]    wr_strb;
    logic [AW_IDX-1:0] rd_idx, wr_idx;
    logic          unused_addr_bits;

    function automatic logic in_range(logic [31:0] a);
        return a[31:AW_IDX+2] == BASE[31:AW_IDX+2];
    endfunction

`ifdef LSU_SRAM_RAND_DELAY_EN
    logic [3:0] lfsr_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) lfsr_q <= 4'b1001;
        else        lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    end
    assign load = 5'(DELAY) + {3'b000, lfsr_q[1:0]};
`else
    assign load = 5'(DELAY);
`endif

    // Reads win over writes when both are presented to an idle slave.
    assign arready = reset & (state_q == StIdle);
    assign awready = reset & (((state_q == StIdle) & ~arvalid) |
                              ((state_q == StWrCollect) & ~aw_got_q));
    assign wready  = reset & (((state_q == StIdle) & ~arvalid) |
                              ((state_q == StWrCollect) & ~w_got_q));

    assign ar_hs   = arvalid & arready;
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    assign aw_have = aw_got_q | aw_hs;
    assign w_have  = w_got_q | w_hs;
    assign commit  = (aw_hs | w_hs) & aw_have & w_have;
    assign wr_addr = aw_hs ? awaddr : awaddr_q;
    assign wr_data = w_hs ? wdata : wdata_q;
    assign wr_strb = w_hs ? wstrb : wstrb_q;
    assign rd_idx  = araddr[AW_IDX+1:2];
    assign wr_idx  = wr_addr[AW_IDX+1:2];
    assign unused_addr_bits = ^{araddr[1:0], wr_addr[1:0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        aw_got_d = aw_got_q;
        w_got_d  = w_got_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        bresp_d  = bresp_q;
        unique case (state_q)
            StIdle, StWrCollect: begin
                if (ar_hs) begin
                    rdata_d = in_range(araddr) ? mem[rd_idx] : 32'h0;
                    rresp_d = in_range(araddr) ? OKAY : SLVERR;
                    cnt_d   = load;
                    state_d = (load == 5'd0) ? StRdResp : StRdWait;
                end else if (commit) begin
                    bresp_d  = in_range(wr_addr) ? OKAY : SLVERR;
                    cnt_d    = load;
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                    state_d  = (load == 5'd0) ? StWrResp : StWrWait;
                end else if (aw_hs | w_hs) begin
                    aw_got_d = aw_have;
                    w_got_d  = w_have;
                    state_d  = StWrCollect;
                end
            end
            StRdWait, StWrWait: begin
                if (cnt_q <= 5'd1) begin
                    cnt_d   = 5'd0;
                    state_d = (state_q == StRdWait) ? StRdResp : StWrResp;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            StRdResp: if (rready) state_d = StIdle;
            StWrResp: if (bready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= 5'd0;
            aw_got_q <= 1'b0;
            w_got_q  <= 1'b0;
            rdata_q  <= 32'h0;
            rresp_q  <= OKAY;
            bresp_q  <= OKAY;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            aw_got_q <= aw_got_d;
            w_got_q  <= w_got_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            bresp_q  <= bresp_d;
        end
    end

    // Channel payload holding registers and storage carry no reset.
    always_ff @(posedge clock) begin
        if (aw_hs) awaddr_q <= awaddr;
        if (w_hs) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
        end
        if (commit && in_range(wr_addr)) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign bvalid = (state_q == StWrResp);
    assign bresp  = bresp_q;
    assign bid    = 4'h0;
    assign rvalid = (state_q == StRdResp);
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;
    assign rlast  = rvalid;
    assign rid    = 4'h0;
endmodule
